// File: rtl/packet_adder_if.sv
// packet_adder_if: bundles the packet input stream and result output stream
// of packet_adder.
//   in_valid/in_ready/in_sop/in_eop/in_data : framed word stream into the adder
//   out_valid/out_ready/out_sum/out_len/out_ovf : per-packet result stream
//   err : one-cycle framing error pulse
// master = packet source / result consumer side, slave = packet_adder side.
interface packet_adder_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16,
    parameter int LEN_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sop;
    logic              in_eop;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [LEN_W-1:0]  out_len;
    logic              out_ovf;
    logic              err;

    modport master (
        output in_valid, in_sop, in_eop, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_len, out_ovf, err
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_len, out_ovf, err
    );
endinterface

// File: rtl/packet_adder.sv
// packet_adder: sums the words of each framed packet and emits one result
// (sum modulo 2^SUM_W, saturating word count, overflow flag) per packet.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : packet_adder_if slave modport (input stream, result stream, err)
//
// state | meaning
// IDLE  | waiting for a sop beat; non-sop beats are dropped with err
// ACCUM | inside a packet, accumulating words until eop
// DONE  | result presented on out_*, input stalled until out_ready
module packet_adder #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    packet_adder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [SUM_W-1:0]   out_sum_q;
    logic [LEN_W-1:0]   out_len_q;
    logic               out_ovf_q;
    logic               accept;
    logic [SUM_W:0]     sum_ext;

    assign accept  = bus.in_valid && in_ready_q;
    // One extra bit captures the carry out of the SUM_W-bit accumulator.
    assign sum_ext = (SUM_W+1)'(acc_q) + (SUM_W+1)'(bus.in_data);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (bus.in_sop) begin
                        // A sop inside a packet abandons the partial packet.
                        err_d   = (state_q == ACCUM);
                        acc_d   = SUM_W'(bus.in_data);
                        len_d   = LEN_W'(1);
                        ovf_d   = 1'b0;
                        state_d = bus.in_eop ? DONE : ACCUM;
                    end else if (state_q == IDLE) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[SUM_W-1:0];
                        ovf_d = ovf_q | sum_ext[SUM_W];
                        if (len_q == LEN_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            len_d = len_q + LEN_W'(1);
                        end
                        if (bus.in_eop) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_len_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d != DONE);
            out_valid_q <= (state_d == DONE);
            // Capture the result only on entry to DONE so it holds afterwards.
            if (state_q != DONE && state_d == DONE) begin
                out_sum_q <= acc_d;
                out_len_q <= len_d;
                out_ovf_q <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_packet_adder.sv
// tb_packet_adder: directed self-checking bench for packet_adder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_packet_adder;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    packet_adder_if #(.DATA_W(8), .SUM_W(16), .LEN_W(8)) bus ();

    packet_adder #(.DATA_W(8), .SUM_W(16), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one beat and hold it until accepted; returns cycles spent waiting.
    task automatic send_beat(input logic [7:0] d, input logic s, input logic e,
                             output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = s;
        bus.in_eop   = e;
        while (bus.in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL beat_accept in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b required 0", bus.in_ready); end
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b required 0", bus.out_valid); end
        vectors++;
        if (bus.out_sum !== 16'h0000 || bus.out_len !== 8'd0 || bus.out_ovf !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_outputs sum=%h len=%0d ovf=%b err=%b required 0/0/0/0",
                     bus.out_sum, bus.out_len, bus.out_ovf, bus.err);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready got %b required 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int w;
        bus.out_ready = 1'b1;
        send_beat(8'h10, 1'b1, 1'b0, w);
        send_beat(8'h20, 1'b0, 1'b0, w);
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %b required 0", bus.out_valid); end
        send_beat(8'h30, 1'b0, 1'b1, w);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency out_valid=%b in_ready=%b required 1/0", bus.out_valid, bus.in_ready);
        end
        vectors++;
        if (bus.out_sum !== 16'h0060 || bus.out_len !== 8'd3 || bus.out_ovf !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result sum=%h len=%0d ovf=%b err=%b required 0060/3/0/0",
                     bus.out_sum, bus.out_len, bus.out_ovf, bus.err);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_one_cycle out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        int w;
        bus.out_ready = 1'b0;
        send_beat(8'hFF, 1'b1, 1'b1, w);
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b1;
        bus.in_eop   = 1'b1;
        bus.in_data  = 8'h7E;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== 16'h00FF || bus.out_len !== 8'd1) begin
                miscompares++;
                $display("FAIL hold_cycle%0d valid=%b in_ready=%b sum=%h len=%0d required 1/0/00ff/1",
                         i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_len);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== 16'h00FF) begin
            miscompares++;
            $display("FAIL release valid=%b in_ready=%b sum=%h required 0/1/00ff",
                     bus.out_valid, bus.in_ready, bus.out_sum);
        end
    endtask

    task automatic test_wrap();
        int w;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_beat(8'hFF, (i == 0), (i == 299), w);
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h2AD4 || bus.out_len !== 8'd255 || bus.out_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_result valid=%b sum=%h len=%0d ovf=%b required 1/2ad4/255/1",
                     bus.out_valid, bus.out_sum, bus.out_len, bus.out_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_framing();
        int w;
        bus.out_ready = 1'b1;
        send_beat(8'h44, 1'b0, 1'b0, w);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.err !== 1'b1) begin miscompares++; $display("FAIL idle_nosop_err got %b required 1", bus.err); end
        @(negedge clk);
        vectors++;
        if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_nosop_drop err=%b valid=%b required 0/0", bus.err, bus.out_valid);
        end
        send_beat(8'h05, 1'b1, 1'b0, w);
        send_beat(8'h06, 1'b0, 1'b0, w);
        vectors++;
        if (bus.err !== 1'b0) begin miscompares++; $display("FAIL inpkt_spurious_err got %b required 0", bus.err); end
        send_beat(8'h01, 1'b1, 1'b1, w);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.err !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0001 || bus.out_len !== 8'd1 || bus.out_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL resop_result err=%b valid=%b sum=%h len=%0d ovf=%b required 1/1/0001/1/0",
                     bus.err, bus.out_valid, bus.out_sum, bus.out_len, bus.out_ovf);
        end
        @(negedge clk);
        vectors++;
        if (bus.err !== 1'b0) begin miscompares++; $display("FAIL err_pulse_width got %b required 0", bus.err); end
    endtask

    task automatic test_reset_mid_packet();
        int w;
        bus.out_ready = 1'b1;
        send_beat(8'h11, 1'b1, 1'b0, w);
        send_beat(8'h22, 1'b0, 1'b0, w);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 16'h0000 || bus.out_len !== 8'd0) begin
            miscompares++;
            $display("FAIL midrst_cleared valid=%b sum=%h len=%0d required 0/0000/0",
                     bus.out_valid, bus.out_sum, bus.out_len);
        end
        send_beat(8'h03, 1'b1, 1'b1, w);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0003 || bus.out_len !== 8'd1 || bus.out_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_next valid=%b sum=%h len=%0d ovf=%b required 1/0003/1/0",
                     bus.out_valid, bus.out_sum, bus.out_len, bus.out_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [6];
        int          plen  [3];
        logic [15:0] psum  [3];
        int          k;
        int          w;
        words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        plen  = '{2, 1, 3};
        psum  = '{16'h0003, 16'h0003, 16'h000F};
        k = 0;
        bus.out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < plen[p]; b++) begin
                send_beat(words[k], (b == 0), (b == plen[p] - 1), w);
                k++;
                if (p > 0 && b == 0) begin
                    vectors++;
                    if (w != 1) begin
                        miscompares++;
                        $display("FAIL b2b_gap pkt%0d waited %0d cycles required 1", p, w);
                    end
                end
            end
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== psum[p] || bus.out_len !== 8'(plen[p])) begin
                miscompares++;
                $display("FAIL b2b_result pkt%0d valid=%b in_ready=%b sum=%h len=%0d required 1/0/%h/%0d",
                         p, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_len, psum[p], plen[p]);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_framing();
        test_reset_mid_packet();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
